// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: immediate format codes
// (same encoding as the decoder's ImmSrc), base opcodes, error codes and FSM states.
package instr_encoder_pkg;

   localparam logic [2:0] IMM_FMT_I = 3'b000;
   localparam logic [2:0] IMM_FMT_S = 3'b001;
   localparam logic [2:0] IMM_FMT_B = 3'b010;
   localparam logic [2:0] IMM_FMT_U = 3'b011;
   localparam logic [2:0] IMM_FMT_J = 3'b100;
   localparam logic [2:0] IMM_FMT_R = 3'b101;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] ENC_ERR_NONE     = 2'b00;
   localparam logic [1:0] ENC_ERR_RANGE    = 2'b01;
   localparam logic [1:0] ENC_ERR_ALIGN    = 2'b10;
   localparam logic [1:0] ENC_ERR_OVERFLOW = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_FULL = 2'd3
   } enc_state_e;

   function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Beat input and instruction-memory write/status bundle of the encoder.
// A beat transfers on a rising clk edge where in_valid and in_ready are both high.
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            in_fmt;
   logic [6:0]            in_opcode;
   logic [2:0]            in_funct3;
   logic [6:0]            in_funct7;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic [31:0]           in_imm;
   logic                  in_last;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic [ADDR_WIDTH-1:0] count;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [1:0]            err_code;

   modport master (
      output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata, count,
             busy, done, err, err_code
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata, count,
             busy, done, err, err_code
   );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range and alignment checks.
// Range failures take priority over alignment failures.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic [1:0]  err_code_o
);

   always_comb begin
      word_o     = '0;
      err_code_o = ENC_ERR_NONE;
      case (fmt_i)
         IMM_FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         IMM_FMT_I: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            if (!imm_in_range(imm_i, -2048, 2047)) err_code_o = ENC_ERR_RANGE;
         end
         IMM_FMT_S: begin
            word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            if (!imm_in_range(imm_i, -2048, 2047)) err_code_o = ENC_ERR_RANGE;
         end
         IMM_FMT_B: begin
            word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
            if (!imm_in_range(imm_i, -4096, 4094)) err_code_o = ENC_ERR_RANGE;
            else if (imm_i[0])                     err_code_o = ENC_ERR_ALIGN;
         end
         IMM_FMT_U: begin
            word_o = {imm_i[31:12], rd_i, opcode_i};
            if (imm_i[11:0] != 12'd0) err_code_o = ENC_ERR_ALIGN;
         end
         IMM_FMT_J: begin
            word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            if (!imm_in_range(imm_i, -1048576, 1048575)) err_code_o = ENC_ERR_RANGE;
            else if (imm_i[0])                           err_code_o = ENC_ERR_ALIGN;
         end
         // Reserved format codes are rejected as an out-of-range immediate.
         default: err_code_o = ENC_ERR_RANGE;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / instruction-memory loader: control FSM, registered
// write port and word counter around the combinational packer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WORDS  = 1024
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   instr_encoder_if.slave bus,
   output enc_state_e     dbg_state_o
);

   localparam int CW = ADDR_WIDTH + 1;

   enc_state_e            state_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [31:0]           wdata_q;
   logic [ADDR_WIDTH-1:0] count_q;
   logic                  err_q;
   logic [1:0]            err_code_q;
   logic [31:0]           pack_word;
   logic [1:0]            pack_err;
   logic [CW-1:0]         next_cnt;
   logic                  in_ready;
   logic                  accept;
   logic                  good;
   logic                  full_hit;

   instr_pack u_pack (
      .fmt_i      (bus.in_fmt),
      .opcode_i   (bus.in_opcode),
      .funct3_i   (bus.in_funct3),
      .funct7_i   (bus.in_funct7),
      .rd_i       (bus.in_rd),
      .rs1_i      (bus.in_rs1),
      .rs2_i      (bus.in_rs2),
      .imm_i      (bus.in_imm),
      .word_o     (pack_word),
      .err_code_o (pack_err)
   );

   // next_cnt counts the word still sitting in the write register, so the
   // address and capacity test stay correct during back-to-back beats.
   always_comb begin
      next_cnt = {1'b0, count_q} + CW'(we_q);
      in_ready = (state_q == ST_RUN) && !start && (next_cnt < CW'(MAX_WORDS));
      accept   = bus.in_valid && in_ready;
      good     = accept && (pack_err == ENC_ERR_NONE);
      full_hit = (state_q == ST_RUN) && we_q
                 && (({1'b0, count_q} + CW'(1)) == CW'(MAX_WORDS));
      addr_d   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(next_cnt << 2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= ENC_ERR_NONE;
      end else begin
         we_q <= good;
         if (good) begin
            addr_q  <= addr_d;
            wdata_q <= pack_word;
         end

         if (start)     count_q <= '0;
         else if (we_q) count_q <= count_q + ADDR_WIDTH'(1);

         // Only the first error cause is recorded until the next start.
         if (start) begin
            err_q      <= 1'b0;
            err_code_q <= ENC_ERR_NONE;
         end else if (!err_q && accept && !good) begin
            err_q      <= 1'b1;
            err_code_q <= pack_err;
         end else if (!err_q && full_hit) begin
            err_q      <= 1'b1;
            err_code_q <= ENC_ERR_OVERFLOW;
         end

         if (start) begin
            state_q <= ST_RUN;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (accept && bus.in_last) state_q <= ST_DONE;
                  else if (full_hit)         state_q <= ST_FULL;
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.busy       = (state_q == ST_RUN);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.err        = err_q;
   assign bus.err_code   = err_code_q;
   assign dbg_state_o    = state_q;

endmodule
